lr35902_sio_shift: RTL and testbench
====================================

// Module: lr35902_sio_shift
// PURPOSE
//  Functional LR35902 serial port (SB at adr=1, SC at adr=0): 8-bit shift
//  register clocked either internally or by an external serial clock. Drives
//  sout/sclk pins and raises the serial IRQ on transfer completion.
//  Sits on the I/O bus beside the timer, feeding the interrupt controller.
//  Optional CGB fast-clock mode (SC bit 1).
// PARAMETERS
//  DIV_BITS       9  normal internal bit period = 2^DIV_BITS clk (H = half period)
//  FAST_DIV_BITS  4  fast-mode bit period = 2^FAST_DIV_BITS clk (>=2)
//  FAST_EN        0  1: SC bit 1 selects fast clock; 0: bit 1 ignored, reads 1
// PORTS
//  clk       in   1  system clock
//  reset     in   1  reset, synchronous, active-high
//  dout      out  8  read data, registered
//  din       in   8  write data
//  adr       in   1  1 = SB, 0 = SC
//  read      in   1  read strobe
//  write     in   1  write strobe; write commits on its falling edge
//  irq       out  1  one-cycle serial interrupt request pulse
//  sout      out  1  serial data out (MSB first)
//  sin       in   1  serial data in (asynchronous)
//  sclk_out  out  1  internal serial clock, idles high
//  sclk_oe   out  1  1 when internal clock selected (SC bit 0 = 1)
//  sclk_in   in   1  external serial clock (asynchronous)
// BEHAVIOUR
//  Reset: sb=0, tstart=0, sclk=0, fast=0, irq=0, sout=1, sclk_out=1, sclk_oe=0,
//   bit count=0, divider=0, dout=0, pwrite=0, sync flops=1. Reset beats all else.
//  Read: each clk with read=1: dout <= adr ? sb : {tstart,5'h1f,FAST_EN?fast:1,sclk}.
//  Write commit: cycle where pwrite=1 && write=0 (pwrite <= write every clk);
//   uses adr/din of that cycle. SB write: sb <= din (allowed mid-transfer; bit
//   count continues). SC write: sclk<=din[0], fast<=din[1]&FAST_EN,
//   both effective next cycle even mid-transfer.
//   din[7]=1 && !tstart: start, tstart<=1, count<=0, divider<=0,
//    sout<=sb[7]; if internal, sclk_out<=0. din[7]=1 && tstart: no restart.
//   din[7]=0 && tstart: abort, tstart<=0, count<=0, sclk_out<=1, no irq.
//  Internal clock (sclk=1): H = 2^(DIV_BITS-1) (fast: 2^(FAST_DIV_BITS-1)).
//   Divider counts while tstart; every H cycles toggle sclk_out. Rising edge:
//   sb<={sb[6:0],sin_sync}, count++. Falling edge: sout<=sb[7].
//  External clock (sclk=0): sclk_in, sin 2-flop synchronised; rising/falling
//   edges of sync'd sclk_in act as above. Edges ignored while tstart=0.
//  Completion: on 8th rising edge, same cycle: tstart<=0, irq<=1,
//   sclk_out stays 1. irq high exactly 1 cycle; irq=0 otherwise.
//  Completion + SC commit same cycle: irq still pulses; SC write then applied
//   against tstart=0 (din[7]=1 starts a new transfer).
//  sout holds last driven bit when idle; sclk_oe = sclk.
//  Bit count is 3-bit + done flag; no wrap into a 9th bit.
// TESTING
//  1 Reset: read SC -> 8'h7e (FAST_EN=0 -> 8'h7f after SC=1 written), SB -> 0, sout=1.
//  2 Internal, DIV_BITS=9, sin=0: SB=A5, SC=81 -> sout 1,0,1,0,0,1,0,1 per 512
//    clk, irq 1-cycle pulse 3840 clk after commit, SB=00, SC reads 7f.
//  3 External: SB=3C, SC=80, drive sclk_in 8 pulses with sin=1 -> SB=FF, irq once;
//    sclk_in pulses before SC write -> SB unchanged, no irq.
//  4 Abort: SC=81, after 3 bits write SC=01 -> tstart=0, no irq, sclk_out=1.
//  5 FAST_EN=1, FAST_DIV_BITS=4: SC=83 -> bits every 16 clk, irq at 120 clk.
//  6 reset asserted mid-transfer -> all outputs reset values next cycle, no irq.

Source files
------------

// File: rtl/lr35902_sio_shift.sv
// LR35902 serial port: SB/SC registers and 8-bit shift engine.
// Internal divided clock or synchronised external clock, MSB first.
module lr35902_sio_shift #(
  parameter int DIV_BITS      = 9,
  parameter int FAST_DIV_BITS = 4,
  parameter bit FAST_EN       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] dout,
  input  logic [7:0] din,
  input  logic       adr,
  input  logic       read,
  input  logic       write,
  output logic       irq,
  output logic       sout,
  input  logic       sin,
  output logic       sclk_out,
  output logic       sclk_oe,
  input  logic       sclk_in
);

  localparam int DW = DIV_BITS;
  localparam logic [DW-1:0] HN_M1 =
    DW'((1 << (DIV_BITS - 1)) - 1);
  localparam logic [DW-1:0] HF_M1 =
    DW'((1 << (FAST_DIV_BITS - 1)) - 1);

  logic [7:0]    r_sb;
  logic          r_tstart;
  logic          r_sclk;
  logic          r_fast;
  logic          r_irq;
  logic          r_sout;
  logic          r_sclk_out;
  logic [2:0]    r_cnt;
  logic [DW-1:0] r_div;
  logic [7:0]    r_dout;
  logic          r_pwrite;
  logic          r_sin_s1;
  logic          r_sin_s2;
  logic          r_sck_s1;
  logic          r_sck_s2;
  logic          r_sck_s3;

  logic [7:0]    w_sb_nx;
  logic          w_tstart_nx;
  logic          w_sclk_nx;
  logic          w_fast_nx;
  logic          w_irq_nx;
  logic          w_sout_nx;
  logic          w_sclk_out_nx;
  logic [2:0]    w_cnt_nx;
  logic [DW-1:0] w_div_nx;
  logic [7:0]    w_dout_nx;
  logic          w_rise;
  logic          w_fall;
  logic          w_commit;
  logic [DW-1:0] w_hm1;

  assign w_commit = r_pwrite & ~write;
  assign w_hm1    = (FAST_EN && r_fast) ? HF_M1 : HN_M1;

  assign dout     = r_dout;
  assign irq      = r_irq;
  assign sout     = r_sout;
  assign sclk_out = r_sclk_out;
  assign sclk_oe  = r_sclk;

  // Next state: clock edges first, then a bus write overrides.
  always_comb begin
    w_sb_nx       = r_sb;
    w_tstart_nx   = r_tstart;
    w_sclk_nx     = r_sclk;
    w_fast_nx     = r_fast;
    w_irq_nx      = 1'b0;
    w_sout_nx     = r_sout;
    w_sclk_out_nx = r_sclk_out;
    w_cnt_nx      = r_cnt;
    w_div_nx      = r_div;
    w_dout_nx     = r_dout;
    w_rise        = 1'b0;
    w_fall        = 1'b0;

    if (read) begin
      w_dout_nx = adr ? r_sb :
        {r_tstart, 5'h1f,
         FAST_EN ? r_fast : 1'b1, r_sclk};
    end

    if (r_tstart) begin
      if (r_sclk) begin
        if (r_div >= w_hm1) begin
          w_div_nx      = '0;
          w_sclk_out_nx = ~r_sclk_out;
          w_rise        = ~r_sclk_out;
          w_fall        = r_sclk_out;
        end else begin
          w_div_nx = r_div + 1'b1;
        end
      end else begin
        w_rise = r_sck_s2 & ~r_sck_s3;
        w_fall = ~r_sck_s2 & r_sck_s3;
      end
    end

    if (w_rise) begin
      w_sb_nx = {r_sb[6:0], r_sin_s2};
      if (r_cnt == 3'd7) begin
        w_tstart_nx = 1'b0;
        w_irq_nx    = 1'b1;
        w_cnt_nx    = 3'd0;
      end else begin
        w_cnt_nx = r_cnt + 3'd1;
      end
    end

    if (w_fall) begin
      w_sout_nx = r_sb[7];
    end

    if (w_commit) begin
      if (adr) begin
        w_sb_nx = din;
      end else begin
        w_sclk_nx = din[0];
        w_fast_nx = din[1] & FAST_EN;
        if (din[7] && !w_tstart_nx) begin
          w_tstart_nx = 1'b1;
          w_cnt_nx    = 3'd0;
          w_div_nx    = '0;
          w_sout_nx   = w_sb_nx[7];
          if (din[0]) begin
            w_sclk_out_nx = 1'b0;
          end
        end else if (!din[7] && w_tstart_nx) begin
          w_tstart_nx   = 1'b0;
          w_cnt_nx      = 3'd0;
          w_sclk_out_nx = 1'b1;
        end
      end
    end
  end

  // State registers and input synchronisers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb       <= 8'h00;
      r_tstart   <= 1'b0;
      r_sclk     <= 1'b0;
      r_fast     <= 1'b0;
      r_irq      <= 1'b0;
      r_sout     <= 1'b1;
      r_sclk_out <= 1'b1;
      r_cnt      <= 3'd0;
      r_div      <= '0;
      r_dout     <= 8'h00;
      r_pwrite   <= 1'b0;
      r_sin_s1   <= 1'b1;
      r_sin_s2   <= 1'b1;
      r_sck_s1   <= 1'b1;
      r_sck_s2   <= 1'b1;
      r_sck_s3   <= 1'b1;
    end else begin
      r_sb       <= w_sb_nx;
      r_tstart   <= w_tstart_nx;
      r_sclk     <= w_sclk_nx;
      r_fast     <= w_fast_nx;
      r_irq      <= w_irq_nx;
      r_sout     <= w_sout_nx;
      r_sclk_out <= w_sclk_out_nx;
      r_cnt      <= w_cnt_nx;
      r_div      <= w_div_nx;
      r_dout     <= w_dout_nx;
      r_pwrite   <= write;
      r_sin_s1   <= sin;
      r_sin_s2   <= r_sin_s1;
      r_sck_s1   <= sclk_in;
      r_sck_s2   <= r_sck_s1;
      r_sck_s3   <= r_sck_s2;
    end
  end

endmodule

// File: tb/tb_lr35902_sio_shift.sv
// Bench for lr35902_sio_shift: elapsed-time reference model,
// per-cycle output compare, directed literals and random traffic.
module tb_lr35902_sio_shift;

  localparam int H = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       adr = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       f_write = 1'b0;
  logic       sin = 1'b0;
  logic       sclk_in = 1'b1;
  logic       rnd = 1'b0;

  logic [7:0] dout, f_dout;
  logic       irq, sout, sclk_out, sclk_oe;
  logic       f_irq, f_sout, f_sclk_out, f_sclk_oe;

  int total = 0;
  int bad = 0;
  int irq_cnt = 0;

  lr35902_sio_shift #(
    .DIV_BITS(9), .FAST_DIV_BITS(4), .FAST_EN(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .dout(dout), .din(din),
    .adr(adr), .read(read), .write(write), .irq(irq),
    .sout(sout), .sin(sin), .sclk_out(sclk_out),
    .sclk_oe(sclk_oe), .sclk_in(sclk_in)
  );

  lr35902_sio_shift #(
    .DIV_BITS(9), .FAST_DIV_BITS(4), .FAST_EN(1'b1)
  ) u_fast (
    .clk(clk), .reset(reset), .dout(f_dout), .din(din),
    .adr(adr), .read(read), .write(f_write), .irq(f_irq),
    .sout(f_sout), .sin(sin), .sclk_out(f_sclk_out),
    .sclk_oe(f_sclk_oe), .sclk_in(sclk_in)
  );

  always #5 clk = ~clk;

  // Reference model: transfer progress as elapsed time / half period.
  logic [7:0] m_sb, m_dout;
  logic m_ts, m_sclk, m_irq, m_sout, m_sco, m_pw;
  logic m_sin1, m_sin2, m_ck1, m_ck2, m_ck3;
  logic m_rise, m_fall;
  int   m_el, m_bits;

  always @(posedge clk) begin
    if (reset) begin
      m_sb = 8'h00; m_dout = 8'h00; m_ts = 1'b0;
      m_sclk = 1'b0; m_irq = 1'b0; m_sout = 1'b1;
      m_sco = 1'b1; m_pw = 1'b0; m_el = 0; m_bits = 0;
      m_sin1 = 1'b1; m_sin2 = 1'b1;
      m_ck1 = 1'b1; m_ck2 = 1'b1; m_ck3 = 1'b1;
    end else begin
      m_irq = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (read)
        m_dout = adr ? m_sb : {m_ts, 5'h1f, 1'b1, m_sclk};
      if (m_ts && m_sclk) begin
        m_el++;
        if (m_el % H == 0) begin
          if ((m_el / H) % 2 == 1) m_rise = 1'b1;
          else m_fall = 1'b1;
        end
      end else if (m_ts) begin
        m_rise = m_ck2 && !m_ck3;
        m_fall = !m_ck2 && m_ck3;
      end
      if (m_rise) begin
        m_sb = {m_sb[6:0], m_sin2};
        m_bits++;
        if (m_sclk) m_sco = 1'b1;
        if (m_bits == 8) begin
          m_ts = 1'b0;
          m_irq = 1'b1;
        end
      end
      if (m_fall) begin
        m_sout = m_sb[7];
        if (m_sclk) m_sco = 1'b0;
      end
      if (m_pw && !write) begin
        if (adr) begin
          m_sb = din;
        end else begin
          m_sclk = din[0];
          if (din[7] && !m_ts) begin
            m_ts = 1'b1; m_bits = 0; m_el = 0;
            m_sout = m_sb[7];
            if (din[0]) m_sco = 1'b0;
          end else if (!din[7] && m_ts) begin
            m_ts = 1'b0; m_bits = 0; m_sco = 1'b1;
          end
        end
      end
      m_pw = write;
      m_sin2 = m_sin1; m_sin1 = sin;
      m_ck3 = m_ck2; m_ck2 = m_ck1; m_ck1 = sclk_in;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd) begin
      sin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) sclk_in = ~sclk_in;
    end
    chk("outs",
        32'({dout, irq, sout, sclk_out, sclk_oe}),
        32'({m_dout, m_irq, m_sout, m_sco, m_sclk}));
    if (irq) irq_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input bit f, input logic a,
                    input logic [7:0] d);
    tick();
    adr = a;
    din = d;
    if (f) f_write = 1'b1;
    else write = 1'b1;
    tick();
    write = 1'b0;
    f_write = 1'b0;
    tick();
  endtask

  task automatic rd(input bit f, input logic a,
                    output logic [7:0] v);
    tick();
    adr = a;
    read = 1'b1;
    tick();
    read = 1'b0;
    v = f ? f_dout : dout;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      sclk_in = 1'b0;
      idle(4);
      sclk_in = 1'b1;
      idle(4);
    end
  endtask

  initial begin
    logic [7:0] v, pat, d;
    int irq_at, nirq, base, op;

    pat = 8'ha5;
    idle(2);
    reset = 1'b0;

    rd(0, 1'b0, v);
    chk("rst_sc", 32'(v), 32'(8'h7e));
    rd(0, 1'b1, v);
    chk("rst_sb", 32'(v), 32'(8'h00));
    chk("rst_sout", 32'(sout), 32'(1'b1));
    wr(0, 1'b0, 8'h01);
    rd(0, 1'b0, v);
    chk("sc_int", 32'(v), 32'(8'h7f));

    rd(1, 1'b0, v);
    chk("f_rst_sc", 32'(v), 32'(8'h7c));
    wr(1, 1'b1, 8'ha5);
    wr(1, 1'b0, 8'h83);
    irq_at = -1;
    nirq = 0;
    for (int m = 0; m <= 200; m++) begin
      if (m > 0) tick();
      if (m % 16 == 8 && m / 16 < 8)
        chk("f_sout", 32'(f_sout), 32'(pat[7 - m / 16]));
      if (f_irq) begin
        nirq++;
        if (irq_at < 0) irq_at = m;
      end
    end
    chk("f_irq_at", irq_at, 120);
    chk("f_irq_n", nirq, 1);
    rd(1, 1'b1, v);
    chk("f_sb", 32'(v), 32'(8'h00));
    rd(1, 1'b0, v);
    chk("f_sc", 32'(v), 32'(8'h7f));

    wr(0, 1'b1, 8'ha5);
    wr(0, 1'b0, 8'h81);
    irq_at = -1;
    nirq = 0;
    for (int m = 0; m <= 3900; m++) begin
      if (m > 0) tick();
      if (m % 512 == 256 && m / 512 < 8)
        chk("int_sout", 32'(sout), 32'(pat[7 - m / 512]));
      if (irq) begin
        nirq++;
        if (irq_at < 0) irq_at = m;
      end
    end
    chk("int_irq_at", irq_at, 3840);
    chk("int_irq_n", nirq, 1);
    rd(0, 1'b1, v);
    chk("int_sb", 32'(v), 32'(8'h00));
    rd(0, 1'b0, v);
    chk("int_sc", 32'(v), 32'(8'h7f));

    base = irq_cnt;
    wr(0, 1'b1, 8'h3c);
    pulses(8);
    idle(8);
    rd(0, 1'b1, v);
    chk("ext_idle_sb", 32'(v), 32'(8'h3c));
    chk("ext_idle_irq", irq_cnt, base);
    sin = 1'b1;
    idle(4);
    wr(0, 1'b0, 8'h80);
    pulses(8);
    idle(8);
    chk("ext_irq", irq_cnt, base + 1);
    rd(0, 1'b1, v);
    chk("ext_sb", 32'(v), 32'(8'hff));
    rd(0, 1'b0, v);
    chk("ext_sc", 32'(v), 32'(8'h7e));

    base = irq_cnt;
    wr(0, 1'b0, 8'h81);
    idle(5 * H + 20);
    wr(0, 1'b0, 8'h01);
    chk("abort_sclk", 32'(sclk_out), 32'(1'b1));
    rd(0, 1'b0, v);
    chk("abort_sc", 32'(v), 32'(8'h7f));
    idle(4000);
    chk("abort_irq", irq_cnt, base);

    base = irq_cnt;
    wr(0, 1'b0, 8'h81);
    idle(1000);
    reset = 1'b1;
    tick();
    chk("rst_mid",
        32'({dout, irq, sout, sclk_out, sclk_oe}),
        32'({8'h00, 1'b0, 1'b1, 1'b1, 1'b0}));
    reset = 1'b0;
    idle(4000);
    chk("rst_mid_irq", irq_cnt, base);
    rd(0, 1'b0, v);
    chk("rst_mid_sc", 32'(v), 32'(8'h7e));

    rnd = 1'b1;
    for (int i = 0; i < 50; i++) begin
      op = int'($urandom_range(0, 4));
      d = 8'($urandom);
      case (op)
        0: wr(0, 1'b1, d);
        1: begin
          if (m_ts) d[0] = m_sclk;
          wr(0, 1'b0, d);
        end
        2: rd(0, 1'($urandom_range(0, 1)), v);
        3: idle(int'($urandom_range(1, 300)));
        default: idle(int'($urandom_range(500, 2500)));
      endcase
    end
    rnd = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
